// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int AXI_WIDTH_DEF = 8;
  localparam int GAP_CNT_W     = 8;
  localparam int MAX_SRC       = 8;

  // Binary index of a one-hot vector (OR of the indices of the set bits).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_SRC; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_arb_pick.sv
// Combinational winner selection for the packet arbiter.
// Default: round-robin search starting at 'start'.
// AXIS_ARB_STRICT_PRIO_EN defined: lowest requesting index wins, 'start' ignored.
module axis_arb_pick #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_SRC-1:0] winner,
  output logic               found
);

`ifdef AXIS_ARB_STRICT_PRIO_EN
  logic [IDX_W-1:0] unused_start_s;
  assign unused_start_s = start;

  // Isolate the lowest set request bit
  always_comb begin
    winner = req & (NUM_SRC'(0) - req);
    found  = |req;
  end
`else
  logic [2*NUM_SRC-1:0] dbl_s;
  logic [2*NUM_SRC-1:0] rot_s;
  logic [NUM_SRC-1:0]   rot_req_s;
  logic [NUM_SRC-1:0]   iso_s;
  logic [2*NUM_SRC-1:0] back_s;

  // Rotate so 'start' sits at bit 0, take lowest set bit, rotate back
  always_comb begin
    dbl_s     = {req, req};
    rot_s     = dbl_s >> start;
    rot_req_s = rot_s[NUM_SRC-1:0];
    iso_s     = rot_req_s & (NUM_SRC'(0) - rot_req_s);
    back_s    = {iso_s, iso_s} << start;
    winner    = back_s[2*NUM_SRC-1:NUM_SRC];
    found     = |req;
  end
`endif

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular AXI-Stream arbiter: NUM_SRC sources share one egress.
// A grant is held from first beat to the last beat, followed by GAP_CYCLES
// idle cycles. Round-robin selection by default; define
// AXIS_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int AXI_WIDTH  = AXI_WIDTH_DEF,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC*AXI_WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]           s_axis_valid,
  input  logic [NUM_SRC-1:0]           s_axis_last,
  output logic [NUM_SRC-1:0]           s_axis_ready,
  output logic [AXI_WIDTH-1:0]         m_axis_data,
  output logic                         m_axis_valid,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic [NUM_SRC-1:0]           grant,
  output logic                         busy
);

  localparam int IDX_W    = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  arb_state_t           state_r, state_nxt_s;
  logic [NUM_SRC-1:0]   grant_r, grant_nxt_s;
  logic [IDX_W-1:0]     last_owner_r, last_owner_nxt_s;
  logic [GAP_CNT_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [IDX_W-1:0]     start_s;
  logic [IDX_W-1:0]     owner_idx_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [NUM_SRC-1:0]   win_s;
  logic                 found_s;
  logic                 hs_s;

  // Search begins one past the previous owner, wrapping at NUM_SRC
  assign start_s = (last_owner_r == LAST_IDX) ? {IDX_W{1'b0}} : (last_owner_r + IDX_W'(1));

  assign owner_idx_s = IDX_W'(onehot_to_idx(MAX_SRC'(grant_r)));
  assign win_idx_s   = IDX_W'(onehot_to_idx(MAX_SRC'(win_s)));

  axis_arb_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (s_axis_valid),
    .start  (start_s),
    .winner (win_s),
    .found  (found_s)
  );

  // Egress mux: pass-through from the owner only while transferring
  always_comb begin
    m_axis_data  = {AXI_WIDTH{1'b0}};
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = {NUM_SRC{1'b0}};
    if (state_r == XFER) begin
      m_axis_data  = s_axis_data[owner_idx_s*AXI_WIDTH +: AXI_WIDTH];
      m_axis_valid = s_axis_valid[owner_idx_s];
      m_axis_last  = s_axis_last[owner_idx_s];
      s_axis_ready = grant_r & {NUM_SRC{m_axis_ready}};
    end else begin
      m_axis_data  = {AXI_WIDTH{1'b0}};
      m_axis_valid = 1'b0;
      m_axis_last  = 1'b0;
      s_axis_ready = {NUM_SRC{1'b0}};
    end
  end

  assign hs_s = m_axis_valid & m_axis_ready;

  // Next-state logic: arbitrate in IDLE, hold until last beat, then idle gap
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_owner_nxt_s = last_owner_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s      = XFER;
          grant_nxt_s      = win_s;
          last_owner_nxt_s = win_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (hs_s && m_axis_last) begin
          grant_nxt_s   = {NUM_SRC{1'b0}};
          gap_cnt_nxt_s = GAP_CNT_W'(GAP_LOAD);
          state_nxt_s   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      GAP: begin
        if (gap_cnt_r == {GAP_CNT_W{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - GAP_CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // State, grant, round-robin pointer and gap counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_SRC{1'b0}};
      last_owner_r <= LAST_IDX;
      gap_cnt_r    <= {GAP_CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: packet-level source model with
// a timestamp-based reference of grant, gap and pass-through behaviour.
module tb_axis_pkt_arbiter;

  localparam int N = 2;
  localparam int W = 8;
  localparam int G = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_valid, s_last, s_ready;
  logic [W-1:0]   m_data;
  logic           m_valid, m_last, m_ready;
  logic [N-1:0]   grant;
  logic           busy;

  logic [N*W-1:0] z_sdata;
  logic [N-1:0]   z_svalid, z_slast, z_sready;
  logic [W-1:0]   z_mdata;
  logic           z_mvalid, z_mlast, z_mready;
  logic [N-1:0]   z_grant;
  logic           z_busy;

  axis_pkt_arbiter #(.NUM_SRC(N), .AXI_WIDTH(W), .GAP_CYCLES(G)) u_dut (
    .clk(clk), .reset(reset),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_last(s_last), .s_axis_ready(s_ready),
    .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_last(m_last), .m_axis_ready(m_ready),
    .grant(grant), .busy(busy)
  );

  axis_pkt_arbiter #(.NUM_SRC(N), .AXI_WIDTH(W), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .reset(reset),
    .s_axis_data(z_sdata), .s_axis_valid(z_svalid), .s_axis_last(z_slast), .s_axis_ready(z_sready),
    .m_axis_data(z_mdata), .m_axis_valid(z_mvalid), .m_axis_last(z_mlast), .m_axis_ready(z_mready),
    .grant(z_grant), .busy(z_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Source model: per-source beat memory {last, data}
  logic [8:0] mem [N][0:255];
  int         head[N], tail[N], sent[N];
  int         stall_at[N], stall_until[N];
  logic [N-1:0] vreg;
  int         vprob;
  int         rdy_mode;
  int         ready_leak;

  // Reference model: owner (-1 none), last cycle of the gap, previous owner
  int cyc, own, gap_end, lo;

  // Observed egress beats
  int         obs_n;
  int         obs_cyc[0:1023];
  int         obs_src[0:1023];
  logic [7:0] obs_dat[0:1023];
  logic       obs_last[0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int lo_i);
`ifdef AXIS_ARB_STRICT_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(lo_i + k) % N]) return (lo_i + k) % N;
`endif
    return -1;
  endfunction

  task automatic add_pkt(input int s, input int len, input logic [7:0] first, input bit incr);
    for (int b = 0; b < len; b++) begin
      mem[s][tail[s]] = {(b == len - 1), (incr ? (first + 8'(b)) : 8'($urandom))};
      tail[s]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!vreg[i] && head[i] < tail[i] && cyc >= stall_until[i] &&
          int'($urandom_range(99)) < vprob) vreg[i] = 1'b1;
      s_data[i*W +: W] = (head[i] < tail[i]) ? mem[i][head[i]][7:0] : 8'h00;
      s_last[i]        = (head[i] < tail[i]) ? mem[i][head[i]][8] : 1'b0;
    end
    s_valid = vreg;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; sent[i] = 0; stall_at[i] = -1; stall_until[i] = 0;
    end
    vreg = '0; s_valid = '0; s_data = '0; s_last = '0;
    own = -1; gap_end = -1; lo = N - 1; cyc = 0; obs_n = 0; ready_leak = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance model and sources
  task automatic cycle();
    logic [N-1:0] eg, er;
    logic         ev, el, eb;
    logic [7:0]   ed;
    int           nown;
    bit           hs;
    #2;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; eb = 1'b0; ed = 8'h00;
    if (own >= 0) begin
      eb = 1'b1; eg[own] = 1'b1; ev = vreg[own]; el = s_last[own];
      ed = s_data[own*W +: W]; er[own] = m_ready;
    end else if (cyc <= gap_end) begin
      eb = 1'b1;
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("m_last", 32'(m_last), 32'(el));
    chk("m_data", 32'(m_data), 32'(ed));
    chk("s_ready", 32'(s_ready), 32'(er));
    for (int i = 0; i < N; i++)
      if (s_ready[i] === 1'b1 && grant[i] !== 1'b1) ready_leak++;
    if (m_valid === 1'b1 && m_ready && obs_n < 1024) begin
      obs_cyc[obs_n] = cyc; obs_src[obs_n] = (grant == 2'b10) ? 1 : 0;
      obs_dat[obs_n] = m_data; obs_last[obs_n] = m_last; obs_n++;
    end
    hs   = (own >= 0) && vreg[own] && m_ready;
    nown = own;
    if (hs && s_last[own]) begin
      nown = -1; gap_end = cyc + G;
    end else if (own < 0 && cyc > gap_end && (|vreg)) begin
      nown = pick(vreg, lo); lo = nown;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      head[own]++; sent[own]++; vreg[own] = 1'b0;
      if (sent[own] == stall_at[own]) stall_until[own] = cyc + 5;
    end
    own = nown;
    drive();
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((own >= 0 || cyc <= gap_end || head[0] < tail[0] || head[1] < tail[1]) && k < limit) begin
      cycle(); k++;
    end
    chk("drain_in_budget", 32'(k < limit), 32'd1);
  endtask

  initial begin
    int exp_src[4];
    int exp_base[4];
    int idx[N];
    int zhs, zb;

    m_ready = 1'b1; rdy_mode = 0; vprob = 100;
    z_sdata = '0; z_svalid = '0; z_slast = '0; z_mready = 1'b1;
    cyc = 0;

    // Reset values while reset is held
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);

    // Reset asserted mid-packet from source 1
    do_reset();
    add_pkt(1, 6, 8'h10, 1'b1);
    drive();
    while (sent[1] < 2 && cyc < 50) cycle();
    #2;
    chk("midrst_pre_grant", 32'(grant), 32'h2);
    chk("midrst_pre_valid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    chk("midrst_m_last", 32'(m_last), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    do_reset();
    add_pkt(0, 3, 8'h20, 1'b1);
    add_pkt(1, 3, 8'h30, 1'b1);
    drive();
    drain(100);
    chk("postrst_first_src", 32'(obs_src[0]), 32'd0);
    chk("postrst_first_data", 32'(obs_dat[0]), 32'h20);

    // Contention: two 4-beat packets per source, both always requesting
    do_reset();
    add_pkt(0, 4, 8'h40, 1'b1); add_pkt(0, 4, 8'h50, 1'b1);
    add_pkt(1, 4, 8'h60, 1'b1); add_pkt(1, 4, 8'h70, 1'b1);
`ifdef AXIS_ARB_STRICT_PRIO_EN
    exp_src[0] = 0; exp_src[1] = 0; exp_src[2] = 1; exp_src[3] = 1;
    exp_base[0] = 'h40; exp_base[1] = 'h50; exp_base[2] = 'h60; exp_base[3] = 'h70;
`else
    exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 0; exp_src[3] = 1;
    exp_base[0] = 'h40; exp_base[1] = 'h60; exp_base[2] = 'h50; exp_base[3] = 'h70;
`endif
    drive();
    drain(200);
    chk("cont_beats", 32'(obs_n), 32'd16);
    chk("cont_first_cyc", 32'(obs_cyc[0]), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("cont_src", 32'(obs_src[k]), 32'(exp_src[k/4]));
      chk("cont_data", 32'(obs_dat[k]), 32'(exp_base[k/4] + (k % 4)));
      chk("cont_last", 32'(obs_last[k]), 32'((k % 4) == 3));
      if (k > 0) chk("cont_spacing", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'(((k % 4) == 0) ? G + 2 : 1));
    end

    // Backpressure: ready toggles during a 6-beat packet
    do_reset();
    rdy_mode = 1;
    add_pkt(0, 6, 8'hA0, 1'b1);
    add_pkt(1, 2, 8'hB0, 1'b1);
    drive();
    drain(200);
    chk("bp_beats", 32'(obs_n), 32'd8);
    for (int k = 0; k < 6; k++) begin
      chk("bp_src", 32'(obs_src[k]), 32'd0);
      chk("bp_data", 32'(obs_dat[k]), 32'(8'hA0 + 8'(k)));
      chk("bp_last", 32'(obs_last[k]), 32'(k == 5));
    end
    chk("bp_ready_leak", 32'(ready_leak), 32'd0);
    rdy_mode = 0;

    // Owner stall: source 0 drops valid for 5 cycles after its 2nd beat
    do_reset();
    add_pkt(0, 6, 8'hC0, 1'b1);
    add_pkt(1, 3, 8'hD0, 1'b1);
    stall_at[0] = 2;
    drive();
    drain(200);
    chk("stall_beats", 32'(obs_n), 32'd9);
    chk("stall_hold", 32'(obs_cyc[2] - obs_cyc[1]), 32'd6);
    chk("stall_owner_kept", 32'(obs_src[5]), 32'd0);
    chk("stall_next_src", 32'(obs_src[6]), 32'd1);
    chk("stall_next_cyc", 32'(obs_cyc[6] - obs_cyc[5]), 32'(G + 2));
    chk("stall_ready_leak", 32'(ready_leak), 32'd0);

    // Single-beat packets with no gap: one packet every 2 cycles
    do_reset();
    z_svalid = 2'b01; z_slast = 2'b11; z_sdata = {8'h66, 8'h55}; z_mready = 1'b1;
    zhs = 0; zb = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      chk("g0_busy_alt", 32'(z_busy), 32'(k % 2));
      chk("g0_sready", 32'(z_sready), 32'((k % 2) == 1));
      if (z_mvalid === 1'b1 && z_mready) begin
        zhs++;
        chk("g0_data", 32'(z_mdata), 32'h55);
      end
      if (z_busy === 1'b1) zb++;
      @(posedge clk);
      #1;
    end
    chk("g0_packets", 32'(zhs), 32'd10);
    chk("g0_busy_count", 32'(zb), 32'd10);
    z_svalid = '0;

    // Randomized traffic, valid gaps and backpressure against the model
    do_reset();
    vprob = 40; rdy_mode = 2;
    for (int p = 0; p < 15; p++) begin
      add_pkt(0, int'($urandom_range(8, 1)), 8'h00, 1'b0);
      add_pkt(1, int'($urandom_range(8, 1)), 8'h00, 1'b0);
    end
    drive();
    drain(3000);
    chk("rand_beats", 32'(obs_n), 32'(tail[0] + tail[1]));
    idx[0] = 0; idx[1] = 0;
    for (int k = 0; k < obs_n; k++) begin
      chk("rand_sb_data", 32'(obs_dat[k]), 32'(mem[obs_src[k]][idx[obs_src[k]]][7:0]));
      chk("rand_sb_last", 32'(obs_last[k]), 32'(mem[obs_src[k]][idx[obs_src[k]]][8]));
      idx[obs_src[k]]++;
    end
    vprob = 100; rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
